tnn_feature_framer: RTL and testbench



---
 rtl/tnn_pkg.sv | 16 +
 rtl/tnn_thr_quant.sv | 34 +++
 rtl/tnn_feature_framer.sv | 95 +++++++++
 tb/tb_tnn_feature_framer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared constants and types for the TNN feature framer
package tnn_pkg;
  localparam int N_FEAT = 7;
  localparam int RAW_W  = 8;
  localparam int Q_W    = 2;
  localparam int ERR_W  = 8;
  localparam int IDX_W  = 3;

  // Default thresholds sit at the quarter points of the raw range.
  localparam logic [RAW_W-1:0] DEF_T0 = RAW_W'(1 << (RAW_W - 2));
  localparam logic [RAW_W-1:0] DEF_T1 = RAW_W'(2 << (RAW_W - 2));
  localparam logic [RAW_W-1:0] DEF_T2 = RAW_W'(3 << (RAW_W - 2));

  typedef logic [N_FEAT*Q_W-1:0] feat_frame_t;
  typedef logic [Q_W-1:0]        q_t;
endpackage

// File: rtl/tnn_thr_quant.sv
// rtl/tnn_thr_quant.sv - one feature's threshold registers and 2-bit quantizer
module tnn_thr_quant
  import tnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       sel,
  input  logic [RAW_W-1:0] thr,
  input  logic [RAW_W-1:0] x,
  output q_t               q
);

  logic [RAW_W-1:0] t0, t1, t2;

  always_ff @(posedge clk) begin
    if (rst) begin
      t0 <= DEF_T0;
      t1 <= DEF_T1;
      t2 <= DEF_T2;
    end else if (we) begin
      case (sel)
        2'd0:    t0 <= thr;
        2'd1:    t1 <= thr;
        2'd2:    t2 <= thr;
        default: ;
      endcase
    end
  end

  // Thresholds are not sorted; q is just the number of thresholds met.
  assign q = q_t'(x >= t0) + q_t'(x >= t1) + q_t'(x >= t2);

endmodule

// File: rtl/tnn_feature_framer.sv
// rtl/tnn_feature_framer.sv - quantizes raw samples and frames 7 features for the TNN classifier
module tnn_feature_framer
  import tnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RAW_W-1:0] in_data,
  input  logic             in_last,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_feat,
  input  logic [1:0]       cfg_sel,
  input  logic [RAW_W-1:0] cfg_thr,
  output logic             out_valid,
  input  logic             out_ready,
  output feat_frame_t      out_feat,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  if (Q_W != 2) begin : g_qw_check
    $error("tnn_feature_framer supports only Q_W == 2");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  logic [IDX_W-1:0] idx;
  feat_frame_t      collect;
  feat_frame_t      frame_done;
  q_t               q_all [N_FEAT];
  logic             last_slot;
  logic             accept;
  logic             good;
  logic             bad;

  for (genvar i = 0; i < N_FEAT; i++) begin : g_feat
    tnn_thr_quant u_quant (
      .clk (clk),
      .rst (rst),
      .we  (cfg_we && (cfg_feat == IDX_W'(i)) && (cfg_sel != 2'd3)),
      .sel (cfg_sel),
      .thr (cfg_thr),
      .x   (in_data),
      .q   (q_all[i])
    );
  end

  // Collect register with the current beat's quantized value dropped into slot idx.
  always_comb begin
    frame_done = collect;
    for (int i = 0; i < N_FEAT; i++) begin
      if (idx == IDX_W'(i)) frame_done[i*Q_W +: Q_W] = q_all[i];
    end
  end

  assign last_slot = (idx == LAST_IDX);
  assign in_ready  = !(last_slot && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign good      = accept && last_slot && in_last;
  assign bad       = accept && (last_slot != in_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      collect   <= '0;
      out_feat  <= '0;
      out_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= bad;
      if (bad && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;

      if (accept) begin
        if (good || bad) begin
          idx     <= '0;
          collect <= '0;
        end else begin
          idx     <= idx + 1'b1;
          collect <= frame_done;
        end
      end

      // A completing beat can only be accepted when the buffer is free or draining.
      if (good) begin
        out_feat  <= frame_done;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tnn_feature_framer.sv
// tb/tb_tnn_feature_framer.sv - self-checking bench for tnn_feature_framer
module tb_tnn_feature_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        cfg_we;
  logic [2:0]  cfg_feat;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_thr;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_feat;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  tnn_feature_framer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cfg_we    (cfg_we),
    .cfg_feat  (cfg_feat),
    .cfg_sel   (cfg_sel),
    .cfg_thr   (cfg_thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_feat  (out_feat),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x [7];
    logic [13:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          thr_m [7][3];
  int          m_idx;
  int          m_coll [7];
  int          m_err;
  logic [13:0] sb [$];
  bit          use_ovr = 0;
  logic [13:0] ovr_val;
  vec_t        tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int quant(input int f, input int x);
    int q = 0;
    for (int k = 0; k < 3; k++) if (x >= thr_m[f][k]) q++;
    return q;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < 7; f++) begin
      thr_m[f][0] = 64;
      thr_m[f][1] = 128;
      thr_m[f][2] = 192;
    end
    m_idx = 0;
    m_err = 0;
    sb.delete();
  endtask

  task automatic beat(input int x, input bit last);
    int          waitc = 0;
    int          q;
    bit          good;
    bit          bad;
    logic [13:0] fr;
    in_valid = 1'b1;
    in_data  = x[7:0];
    in_last  = last;
    #1;
    while (!in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    q    = quant(m_idx, x);
    good = (m_idx == 6) && last;
    bad  = (m_idx == 6) != last;
    m_coll[m_idx] = q;
    if (good) begin
      fr = '0;
      for (int i = 0; i < 7; i++) fr[2*i +: 2] = m_coll[i][1:0];
      sb.push_back(use_ovr ? ovr_val : fr);
    end
    if (good || bad) m_idx = 0;
    else m_idx++;
    if (bad && m_err < 255) m_err++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("err_pulse", err_pulse, bad);
    chk("err_cnt", err_cnt, m_err);
    if (good) chk("out_valid_latency", out_valid, 1);
  endtask

  task automatic send_frame(input int v [7]);
    for (int i = 0; i < 7; i++) beat(v[i], i == 6);
  endtask

  task automatic cfg_write(input int f, input int s, input int val);
    cfg_we   = 1'b1;
    cfg_feat = f[2:0];
    cfg_sel  = s[1:0];
    cfg_thr  = val[7:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (f < 7 && s != 3) thr_m[f][s] = val;
  endtask

  // Scoreboard: a frame leaves on the edge after a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
      else chk("out_feat", out_feat, sb.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fa [7];
    logic [13:0] held;

    tbl[0].x = '{10, 70, 130, 200, 0, 255, 128};  tbl[0].exp = 14'h2CE4;
    tbl[1].x = '{63, 64, 127, 128, 191, 192, 255}; tbl[1].exp = 14'h3E94;
    tbl[2].x = '{0, 0, 0, 0, 0, 0, 0};             tbl[2].exp = 14'h0000;
    tbl[3].x = '{255, 255, 255, 255, 255, 255, 255}; tbl[3].exp = 14'h3FFF;

    rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0;
    cfg_we = 0; cfg_feat = 0; cfg_sel = 0; cfg_thr = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_feat", out_feat, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    out_ready = 1'b1;

    for (int i = 0; i < 4; i++) begin
      use_ovr = 1; ovr_val = tbl[i].exp;
      send_frame(tbl[i].x);
      use_ovr = 0;
    end

    // Threshold write in the same cycle as the beat that uses it.
    fa = '{100, 100, 6, 100, 100, 100, 100};
    beat(fa[0], 0); beat(fa[1], 0);
    cfg_we = 1; cfg_feat = 3'd2; cfg_sel = 2'd0; cfg_thr = 8'd5;
    beat(fa[2], 0);
    cfg_we = 0; thr_m[2][0] = 5;
    for (int i = 3; i < 7; i++) beat(fa[i], i == 6);
    send_frame(fa);
    cfg_write(2, 0, 64);
    cfg_write(7, 0, 0);
    cfg_write(0, 3, 0);
    use_ovr = 1; ovr_val = tbl[0].exp;
    send_frame(tbl[0].x);
    use_ovr = 0;

    // Early last, then missing last.
    beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 1);
    chk("err_no_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("err_pulse_one_cycle", err_pulse, 0);
    send_frame(tbl[1].x);
    for (int i = 0; i < 7; i++) beat(50 * i, 0);
    chk("err_cnt_two", err_cnt, 2);

    // Output held while the next frame streams in.
    out_ready = 1'b0;
    send_frame(tbl[0].x);
    held = tbl[0].exp;
    for (int i = 0; i < 6; i++) beat(tbl[1].x[i], 0);
    in_valid = 1; in_data = tbl[1].x[6][7:0]; in_last = 1;
    #1;
    chk("hold_in_ready_low", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("hold_out_feat", out_feat, held);
      chk("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    beat(tbl[1].x[6], 1);

    // Reset mid-frame and mid-hold.
    for (int i = 0; i < 4; i++) beat(tbl[3].x[i], 0);
    in_valid = 1; in_data = 8'hff; rst = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    model_reset();
    chk("midframe_rst_out_valid", out_valid, 0);
    chk("midframe_rst_err_cnt", err_cnt, 0);
    out_ready = 1'b0;
    send_frame(tbl[3].x);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    chk("hold_rst_out_valid", out_valid, 0);
    chk("hold_rst_out_feat", out_feat, 0);
    chk("hold_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send_frame(tbl[2].x);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) beat(i & 255, 1);
    chk("err_cnt_saturated", err_cnt, 255);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
